// File: rtl/dot_product_accelerator_pkg.sv
// Shared Q8.24 fixed-point definitions for the classifier datapath
// (dot-product and max accelerators).
package dot_product_accelerator_pkg;

    localparam int unsigned Q_WIDTH   = 32;
    localparam int unsigned FRAC_BITS = 24;

    typedef logic [Q_WIDTH-1:0] q_word_t;

    localparam q_word_t Q_MAX = 32'h7FFF_FFFF;
    localparam q_word_t Q_MIN = 32'h8000_0000;
    localparam q_word_t Q_ONE = 32'h0100_0000;

    // Sideband bits that travel with each product through the multiply stage.
    typedef struct packed {
        logic valid;
        logic last;
    } term_tag_t;

endpackage

// File: rtl/fixed_mul_q824.sv
// Registered signed Q-format multiply: full 64-bit product, floor-shift by FRAC_BITS,
// sign-extended to ACC_W, with valid/last carried alongside.
module fixed_mul_q824 #(
    parameter int unsigned FRAC_BITS = dot_product_accelerator_pkg::FRAC_BITS,
    parameter int unsigned ACC_W     = 48
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic                    last_i,
    input  logic [31:0]             a_i,
    input  logic [31:0]             b_i,
    output logic                    valid_o,
    output logic                    last_o,
    output logic signed [ACC_W-1:0] prod_o
);
    import dot_product_accelerator_pkg::*;

    logic signed [63:0]      full_prod;
    logic signed [63:0]      shifted;
    logic signed [ACC_W-1:0] prod_d, prod_q;
    term_tag_t               tag_d, tag_q;

    always_comb begin
        full_prod = $signed(a_i) * $signed(b_i);
        // Arithmetic shift floors toward -inf for negative products.
        shifted   = full_prod >>> FRAC_BITS;
        prod_d    = ACC_W'(shifted);
        tag_d     = '{valid: valid_i, last: valid_i & last_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q  <= '0;
            prod_q <= '0;
        end else begin
            tag_q <= tag_d;
            if (valid_i) begin
                prod_q <= prod_d;
            end
        end
    end

    assign valid_o = tag_q.valid;
    assign last_o  = tag_q.last;
    assign prod_o  = prod_q;

endmodule

// File: rtl/dot_product_accelerator.sv
// Streaming Q8.24 dot product: registered multiply, then accumulate VEC_LEN terms
// and emit one saturated 32-bit score per vector.
module dot_product_accelerator #(
    parameter int unsigned VEC_LEN   = 4,
    parameter int unsigned FRAC_BITS = dot_product_accelerator_pkg::FRAC_BITS,
    parameter int unsigned ACC_W     = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aIn,
    input  logic [31:0] wIn,
    input  logic        inValid,
    output logic [31:0] outData,
    output logic        outValid,
    output logic        satFlag
);
    import dot_product_accelerator_pkg::*;

    localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    term_last;
    logic                    s1_valid, s1_last;
    logic signed [ACC_W-1:0] s1_prod;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic [ACC_W-Q_WIDTH:0]  sum_hi;
    logic                    clip;
    q_word_t                 sat_data;
    q_word_t                 out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sat_q, sat_d;

    always_comb begin
        term_last = (cnt_q == LAST_CNT);
        cnt_d     = cnt_q;
        if (inValid) begin
            cnt_d = term_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    fixed_mul_q824 #(
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mul (
        .clk_i   (clk),
        .rst_i   (reset),
        .valid_i (inValid),
        .last_i  (term_last),
        .a_i     (aIn),
        .b_i     (wIn),
        .valid_o (s1_valid),
        .last_o  (s1_last),
        .prod_o  (s1_prod)
    );

    always_comb begin
        sum    = acc_q + s1_prod;
        // In range iff every bit from bit 31 upward matches the sign.
        sum_hi = sum[ACC_W-1:Q_WIDTH-1];
        clip   = !((&sum_hi) || !(|sum_hi));
        if (clip) begin
            sat_data = sum[ACC_W-1] ? Q_MIN : Q_MAX;
        end else begin
            sat_data = sum[Q_WIDTH-1:0];
        end

        acc_d       = acc_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        out_valid_d = s1_valid && s1_last;
        if (s1_valid) begin
            acc_d = s1_last ? '0 : sum;
        end
        if (s1_valid && s1_last) begin
            out_data_d = sat_data;
            sat_d      = clip;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign satFlag  = sat_q;

endmodule

// File: doc/dot_product_accelerator.md
# dot_product_accelerator

Streaming fixed-point dot-product stage that sits directly upstream of the max accelerator in the classifier datapath. It accepts one (activation, weight) pair per cycle in signed Q8.24. It multiplies and accumulates VEC_LEN terms, then emits one saturated Q8.24 score per vector. Its outData/outValid pair drives the max accelerator's data and valid inputs directly, with no glue logic.

## Interface
- VEC_LEN, 4: terms per dot product; must be ≥1.
- FRAC_BITS, 24: fractional bits of the Q format; word width is fixed at 32.
- ACC_W, 48: signed internal accumulator width; must be ≥ 64−FRAC_BITS + clog2(VEC_LEN).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- aIn  in  32  activation, signed Q8.24.
- wIn  in  32  weight, signed Q8.24.
- inValid  in  1  aIn/wIn are a valid term this cycle; no backpressure, so every valid term is accepted.
- outData  out  32  last dot-product result, signed Q8.24, held until the next result.
- outValid  out  1  one-cycle pulse per completed vector.
- satFlag  out  1  the result currently on outData was clipped.

## Operation
- Stage 1 (multiply):
  - On each valid term, forms the full signed 64-bit product of aIn and wIn.
  - Arithmetic-shifts the product right by FRAC_BITS, truncating toward −∞.
  - Registers the result sign-extended to ACC_W, together with a valid bit and a last bit.
  - last = the term counter equals VEC_LEN−1.
- Term counter: counts accepted terms from 0 to VEC_LEN−1 and wraps to 0 on the last term. Invalid cycles are bubbles; the counter and the accumulator hold.
- Stage 2 (accumulate):
  - When the stage-1 valid bit is set and last is clear: acc ← acc + product.
  - When the stage-1 valid bit is set and last is set, in the same edge:
    - outData ← sat32(acc + product)
    - satFlag ← the clip indicator
    - outValid ← 1
    - acc ← 0
- Saturation: clip to 0x7FFF_FFFF or 0x8000_0000 when the ACC_W sum falls outside the 32-bit signed range. Otherwise take the low 32 bits.
- VEC_LEN = 1: every term is last, giving one result per valid input.
- Back-to-back vectors: the first term of the next vector may arrive on the cycle immediately after the previous last term. The accumulator clear and the next product do not interfere.

## Timing
- Reset values:
  - outData = 0, outValid = 0, satFlag = 0.
  - acc = 0, term counter = 0, stage-1 valid = 0.
- Reset mid-vector discards the partial sum and any in-flight product. The next valid term is term 0.
- Reset has priority over a simultaneous valid input or last-term completion.
- Latency: last term sampled at edge E → outValid high for exactly the cycle after edge E+1 (2-cycle latency).
- Throughput: 1 term/cycle; one result per VEC_LEN valid cycles.
- outValid is never high on two consecutive cycles unless VEC_LEN = 1.
- outData and satFlag change only on edges where outValid is set to 1.

## Structure
- Shared package (used with the max accelerator):
  - Q_WIDTH = 32, FRAC_BITS = 24.
  - Q_MAX = 32'h7FFF_FFFF, Q_MIN = 32'h8000_0000.
  - Q_ONE = 32'h0100_0000.
  - A q_word_t typedef.
- One sub-module, fixed_mul_q824: the registered signed multiply and shift of stage 1, carrying valid/last alongside the product.
- The counter, accumulator and saturation logic stay in the top module.

## Test plan
- Basic product, VEC_LEN=4:
  - Stimulus: a = 0x0100_0000, 0x0200_0000, 0x0300_0000, 0x0400_0000 with w = 0x0080_0000 each.
  - Required: outData = 0x0500_0000 (5.0), satFlag = 0, single outValid pulse 2 cycles after the last input.
- Mixed signs:
  - Stimulus: (−2.0 × 1.5) + (1.0 × 1.0) + (0.5 × −2.0) + (0 × 3.0), i.e. a = 0xFE00_0000, 0x0100_0000, 0x0080_0000, 0; w = 0x0180_0000, 0x0100_0000, 0xFE00_0000, 0x0300_0000.
  - Required: outData = 0xFD00_0000 (−3.0).
- Saturation:
  - Stimulus: four terms of 0x7F00_0000 × 0x7F00_0000.
  - Required: 0x7FFF_FFFF, satFlag = 1.
  - Stimulus: the same with w = 0x8100_0000.
  - Required: 0x8000_0000, satFlag = 1.
  - Stimulus: a following normal vector.
  - Required: satFlag returns to 0.
- Truncation:
  - Stimulus: four terms a = 0xFFFF_FFFF, w = 0x0080_0000.
  - Required: each term floors to −1 LSB, giving outData = 0xFFFF_FFFC.
- Streaming:
  - Stimulus: two vectors back-to-back with no bubble, then a third with inValid low on two interleaved cycles.
  - Required: three correct results, each outValid a one-cycle pulse, no cross-vector contamination.
- Reset mid-vector:
  - Stimulus: assert reset after 2 terms of a vector.
  - Required: all outputs 0 on the next cycle.
  - Stimulus: a fresh 4-term vector.
  - Required: the exact result, with no residue from the discarded terms.
